// File: rtl/selector.sv
// rtl/selector.sv - Viterbi ACS output stage: minimum-metric survivor select and window refresh pulse.
module selector #(
  parameter int PATH_W   = 8,
  parameter int METRIC_W = 4,
  parameter int PTR_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [PATH_W-1:0]   updated_selected_branch_at_00,
  input  logic [PATH_W-1:0]   updated_selected_branch_at_01,
  input  logic [PATH_W-1:0]   updated_selected_branch_at_10,
  input  logic [PATH_W-1:0]   updated_selected_branch_at_11,
  input  logic [METRIC_W-1:0] new_branch_metric_00,
  input  logic [METRIC_W-1:0] new_branch_metric_01,
  input  logic [METRIC_W-1:0] new_branch_metric_10,
  input  logic [METRIC_W-1:0] new_branch_metric_11,
  input  logic [PTR_W-1:0]    write_pointer_in,
  output logic [PATH_W-1:0]   out,
  output logic                refresh
);

  logic [METRIC_W-1:0] w_lo_metric;
  logic [PATH_W-1:0]   w_lo_path;
  logic [METRIC_W-1:0] w_hi_metric;
  logic [PATH_W-1:0]   w_hi_path;
  logic [PATH_W-1:0]   w_best_path;
  logic                w_wrap;

  logic [PATH_W-1:0]   r_out;
  logic                r_refresh;

  // Strict less-than replaces the incumbent, so equal metrics keep the lower state.
  always_comb begin
    w_lo_metric = new_branch_metric_00;
    w_lo_path   = updated_selected_branch_at_00;
    if (new_branch_metric_01 < new_branch_metric_00) begin
      w_lo_metric = new_branch_metric_01;
      w_lo_path   = updated_selected_branch_at_01;
    end

    w_hi_metric = new_branch_metric_10;
    w_hi_path   = updated_selected_branch_at_10;
    if (new_branch_metric_11 < new_branch_metric_10) begin
      w_hi_metric = new_branch_metric_11;
      w_hi_path   = updated_selected_branch_at_11;
    end

    w_best_path = w_lo_path;
    if (w_hi_metric < w_lo_metric) begin
      w_best_path = w_hi_path;
    end
  end

  assign w_wrap = (write_pointer_in == {PTR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out     <= '0;
      r_refresh <= 1'b0;
    end else begin
      if (valid_in) begin
        r_out <= w_best_path;
      end
      r_refresh <= valid_in & w_wrap;
    end
  end

  assign out     = r_out;
  assign refresh = r_refresh;

endmodule

// File: tb/tb_selector.sv
// tb/tb_selector.sv - Randomized and directed self-checking bench for selector.
module tb_selector;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [7:0] p [4];
  logic [3:0] m [4];
  logic [2:0] wp;
  logic [7:0] out;
  logic       refresh;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_out;
  logic       exp_refresh;

  selector #(.PATH_W(8), .METRIC_W(4), .PTR_W(3)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .valid_in                      (valid_in),
    .updated_selected_branch_at_00 (p[0]),
    .updated_selected_branch_at_01 (p[1]),
    .updated_selected_branch_at_10 (p[2]),
    .updated_selected_branch_at_11 (p[3]),
    .new_branch_metric_00          (m[0]),
    .new_branch_metric_01          (m[1]),
    .new_branch_metric_10          (m[2]),
    .new_branch_metric_11          (m[3]),
    .write_pointer_in              (wp),
    .out                           (out),
    .refresh                       (refresh)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the survivor is the first state, in index order, holding the minimum metric.
  function automatic logic [7:0] ref_best(input logic [7:0] pp [4], input logic [3:0] mm [4]);
    int best_i = 0;
    for (int i = 1; i < 4; i++)
      if (mm[i] < mm[best_i]) best_i = i;
    return pp[best_i];
  endfunction

  task automatic beat(input logic v, input logic r, input logic [2:0] ptr,
                      input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] p3,
                      input logic [3:0] m0, input logic [3:0] m1, input logic [3:0] m2, input logic [3:0] m3,
                      input string tag);
    valid_in = v; rst = r; wp = ptr;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    m[0] = m0; m[1] = m1; m[2] = m2; m[3] = m3;
    if (r) begin
      exp_out = 8'h00;
      exp_refresh = 1'b0;
    end else begin
      if (v) exp_out = ref_best(p, m);
      exp_refresh = v && (ptr == 3'd7);
    end
    @(posedge clk);
    #1;
    check({tag, ".out"}, {24'd0, out}, {24'd0, exp_out});
    check({tag, ".refresh"}, {31'd0, refresh}, {31'd0, exp_refresh});
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; wp = 3'd0;
    for (int i = 0; i < 4; i++) begin p[i] = 8'h5A; m[i] = 4'd9; end
    exp_out = 8'h00; exp_refresh = 1'b0;
    @(posedge clk); #1;
    beat(1'b1, 1'b1, 3'd7, 8'h11, 8'h22, 8'h33, 8'h44, 4'd1, 4'd2, 4'd3, 4'd4, "reset");

    beat(1'b1, 1'b0, 3'd0, 8'hAA, 8'hCC, 8'hF0, 8'h0F, 4'd1, 4'd2, 4'd3, 4'd4, "basic");
    beat(1'b1, 1'b0, 3'd1, 8'h0F, 8'hF0, 8'hAA, 8'h55, 4'd2, 4'd2, 4'd2, 4'd2, "tie2");
    beat(1'b1, 1'b0, 3'd1, 8'h00, 8'hFF, 8'hAA, 8'h55, 4'd5, 4'd5, 4'd5, 4'd5, "tie5");
    beat(1'b1, 1'b0, 3'd2, 8'hFF, 8'h00, 8'hAA, 8'h55, 4'd0, 4'd15, 4'd7, 4'd8, "extreme0");
    beat(1'b1, 1'b0, 3'd2, 8'hFF, 8'h00, 8'hAA, 8'h55, 4'd13, 4'd14, 4'd15, 4'd0, "state11");
    beat(1'b1, 1'b0, 3'd3, 8'h11, 8'h22, 8'h33, 8'h44, 4'd9, 4'd3, 4'd3, 4'd9, "tie01_10");
    beat(1'b1, 1'b0, 3'd3, 8'h11, 8'h22, 8'h33, 8'h44, 4'd9, 4'd9, 4'd4, 4'd4, "tie10_11");
    beat(1'b1, 1'b0, 3'd7, 8'h33, 8'hCC, 8'hAA, 8'h55, 4'd5, 4'd6, 4'd7, 4'd8, "wrap");
    beat(1'b1, 1'b0, 3'd4, 8'h33, 8'hCC, 8'hAA, 8'h55, 4'd5, 4'd6, 4'd7, 4'd8, "after_wrap");
    beat(1'b0, 1'b0, 3'd3, 8'h99, 8'h88, 8'h77, 8'h66, 4'd0, 4'd1, 4'd2, 4'd3, "hold");
    beat(1'b0, 1'b0, 3'd7, 8'h99, 8'h88, 8'h77, 8'h66, 4'd0, 4'd1, 4'd2, 4'd3, "hold_wp7");
    beat(1'b1, 1'b0, 3'd0, 8'hAA, 8'hCC, 8'hF0, 8'h0F, 4'd4, 4'd3, 4'd2, 4'd1, "rev");
    beat(1'b1, 1'b1, 3'd7, 8'hAA, 8'hCC, 8'hF0, 8'h0F, 4'd4, 4'd3, 4'd2, 4'd1, "midreset");
    beat(1'b0, 1'b0, 3'd0, 8'h12, 8'h34, 8'h56, 8'h78, 4'd0, 4'd0, 4'd0, 4'd0, "post_reset_idle");
    beat(1'b1, 1'b0, 3'd5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'd6, 4'd2, 4'd9, 4'd2, "resume");

    for (int n = 0; n < 400; n++) begin
      logic [31:0] r0, r1;
      r0 = $urandom; r1 = $urandom;
      beat(($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0), 3'($urandom_range(0, 7)),
           r0[7:0], r0[15:8], r0[23:16], r0[31:24],
           // Narrow metric range on some beats to exercise ties often.
           (r1[16] ? {2'b00, r1[1:0]} : r1[3:0]), (r1[16] ? {2'b00, r1[5:4]} : r1[7:4]),
           (r1[16] ? {2'b00, r1[9:8]} : r1[11:8]), (r1[16] ? {2'b00, r1[13:12]} : r1[15:12]),
           "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
